// File: rtl/reuleaux_pkg.sv
// reuleaux_pkg: shared states, screen geometry and engine indices for the Reuleaux scheduler
package reuleaux_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] CLEAR_COLOUR = 3'b000;
  localparam int K_Q8 = 74;
  localparam int ARC_LEFT = 0;
  localparam int ARC_RIGHT = 1;
  localparam int ARC_TOP = 2;
  typedef enum logic [3:0] {IDLE, CALC, CHECK, CLEAR, ARC0, REL0, ARC1, REL1, ARC2, REL2, DONE} state_t;
  function automatic logic off_screen(logic [9:0] v, int lim);
    return v[9] || int'(v) >= lim;
  endfunction
endpackage

// File: rtl/reuleaux_centres.sv
// reuleaux_centres: registered vertex-centre geometry and on-screen range check
module reuleaux_centres
  import reuleaux_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [7:0]      centre_x,
  input  logic [7:0]      centre_y,
  input  logic [7:0]      diameter,
  output logic [2:0][7:0] cx,
  output logic [2:0][7:0] cy,
  output logic            bad
);
  logic [9:0] h, k1, k2, bx, by;
  logic [2:0][9:0] x, y;
  logic oob;
  always_comb begin
    h = 10'(diameter >> 1);
    k1 = 10'((32'(diameter) * K_Q8) >> 8);
    k2 = 10'((32'(diameter) * (2 * K_Q8)) >> 8);
    bx = {2'b00, centre_x};
    by = {2'b00, centre_y};
    x[ARC_LEFT] = bx - h;
    y[ARC_LEFT] = by + k1;
    x[ARC_RIGHT] = bx + h;
    y[ARC_RIGHT] = by + k1;
    x[ARC_TOP] = bx;
    y[ARC_TOP] = by - k2;
    oob = 1'b0;
    for (int i = 0; i < 3; i++)
      oob = oob | off_screen(x[i], SCREEN_W) | off_screen(y[i], SCREEN_H);
  end
  always_ff @(posedge clk)
    if (rst) begin
      cx <= '0;
      cy <= '0;
      bad <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < 3; i++) begin
        cx[i] <= x[i][7:0];
        cy[i] <= y[i][7:0];
      end
      bad <= oob;
    end
endmodule

// File: rtl/reuleaux_sched.sv
// reuleaux_sched: sequences optional screen clear and three arc engines onto one VGA plot port
module reuleaux_sched
  import reuleaux_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clear_en,
  input  logic [7:0]      centre_x,
  input  logic [7:0]      centre_y,
  input  logic [7:0]      diameter,
  input  logic [2:0]      colour,
  output logic            finished,
  output logic            err,
  output logic [2:0]      arc_start,
  input  logic [2:0]      arc_finished,
  output logic [2:0][7:0] arc_cx,
  output logic [2:0][7:0] arc_cy,
  output logic [7:0]      arc_radius,
  output logic [2:0]      arc_colour,
  input  logic [2:0][7:0] arc_vga_x,
  input  logic [2:0][6:0] arc_vga_y,
  input  logic [2:0]      arc_vga_plot,
  output logic [7:0]      vga_x,
  output logic [6:0]      vga_y,
  output logic [2:0]      vga_colour,
  output logic            vga_plot
);
  state_t state, next;
  logic clear_q, bad, x_last, clr_last, arc_on;
  logic [7:0] clr_x;
  logic [6:0] clr_y;
  logic [1:0] k;
  reuleaux_centres u_centres (
    .clk(clk),
    .rst(rst),
    .load(state == CALC),
    .centre_x(centre_x),
    .centre_y(centre_y),
    .diameter(diameter),
    .cx(arc_cx),
    .cy(arc_cy),
    .bad(bad)
  );
  assign x_last = clr_x == 8'(SCREEN_W - 1);
  assign clr_last = x_last && clr_y == 7'(SCREEN_H - 1);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      clear_q <= 1'b0;
      arc_radius <= '0;
      arc_colour <= '0;
      clr_x <= '0;
      clr_y <= '0;
    end else begin
      state <= next;
      if (state == CALC) begin
        clear_q <= clear_en;
        arc_radius <= diameter;
        arc_colour <= colour;
      end
      if (state == CLEAR) begin
        clr_x <= x_last ? 8'd0 : clr_x + 8'd1;
        clr_y <= clr_last ? 7'd0 : clr_y + 7'(x_last);
      end
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? CALC : IDLE;
      CALC:    next = CHECK;
      CHECK:   next = bad ? DONE : clear_q ? CLEAR : ARC0;
      CLEAR:   next = clr_last ? ARC0 : CLEAR;
      ARC0:    next = arc_finished[ARC_LEFT] ? REL0 : ARC0;
      REL0:    next = arc_finished[ARC_LEFT] ? REL0 : ARC1;
      ARC1:    next = arc_finished[ARC_RIGHT] ? REL1 : ARC1;
      REL1:    next = arc_finished[ARC_RIGHT] ? REL1 : ARC2;
      ARC2:    next = arc_finished[ARC_TOP] ? REL2 : ARC2;
      REL2:    next = arc_finished[ARC_TOP] ? REL2 : DONE;
      DONE:    next = start ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    arc_start = '0;
    arc_start[ARC_LEFT] = state == ARC0;
    arc_start[ARC_RIGHT] = state == ARC1;
    arc_start[ARC_TOP] = state == ARC2;
    k = state == ARC1 ? 2'd1 : state == ARC2 ? 2'd2 : 2'd0;
    arc_on = |arc_start;
    vga_x = arc_on ? arc_vga_x[k] : state == CLEAR ? clr_x : '0;
    vga_y = arc_on ? arc_vga_y[k] : state == CLEAR ? clr_y : '0;
    vga_plot = arc_on ? arc_vga_plot[k] : state == CLEAR;
    vga_colour = state == CLEAR ? CLEAR_COLOUR : arc_colour;
    finished = state == DONE;
    err = finished & bad;
  end
endmodule

// File: tb/tb_reuleaux_sched.sv
// tb_reuleaux_sched: randomized stub arc engines checked against a pixel-queue reference model
module tb_reuleaux_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic clear_en = 1'b0;
  logic [7:0] centre_x = '0, centre_y = '0, diameter = '0;
  logic [2:0] colour = '0;
  logic finished, err, vga_plot;
  logic [2:0] arc_start, arc_colour, vga_colour;
  logic [2:0] arc_finished = '0;
  logic [2:0][7:0] arc_cx, arc_cy;
  logic [7:0] arc_radius, vga_x;
  logic [6:0] vga_y;
  logic [2:0][7:0] arc_vga_x = '0;
  logic [2:0][6:0] arc_vga_y = '0;
  logic [2:0] arc_vga_plot = '0;
  typedef struct {int x; int y; int c; int kind;} pix_t;
  pix_t q[$];
  pix_t ce;
  logic [2:0] seq[$];
  int vectors = 0, miscompares = 0, plots = 0, last_err = 0;
  int sn[3], shold[3], idx[3], hc[3];
  int sx[3][8], sy[3][8];
  int ex[3], ey[3];
  logic [2:0] fin = '0, p_start = '0, p_fin = '0;
  bit exp_bad, p_more, p_last, c_more, c_last;

  always #5 clk = ~clk;

  reuleaux_sched dut (
    .clk(clk), .rst(rst), .start(start), .clear_en(clear_en),
    .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter), .colour(colour),
    .finished(finished), .err(err), .arc_start(arc_start), .arc_finished(arc_finished),
    .arc_cx(arc_cx), .arc_cy(arc_cy), .arc_radius(arc_radius), .arc_colour(arc_colour),
    .arc_vga_x(arc_vga_x), .arc_vga_y(arc_vga_y), .arc_vga_plot(arc_vga_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        fin[k] = 1'b0;
        idx[k] = 0;
        hc[k] = 0;
        arc_vga_plot[k] = 1'b0;
      end else if (arc_start[k] && !fin[k]) begin
        arc_vga_x[k] = 8'($urandom);
        arc_vga_y[k] = 7'($urandom);
        arc_vga_plot[k] = 1'b0;
        if (idx[k] >= sn[k]) fin[k] = 1'b1;
        else if ($urandom_range(0, 2) != 0) begin
          arc_vga_x[k] = 8'(sx[k][idx[k]]);
          arc_vga_y[k] = 7'(sy[k][idx[k]]);
          arc_vga_plot[k] = 1'b1;
          idx[k]++;
        end
      end else if (arc_start[k]) arc_vga_plot[k] = 1'b0;
      else begin
        arc_vga_x[k] = 8'($urandom);
        arc_vga_y[k] = 7'($urandom);
        arc_vga_plot[k] = 1'($urandom_range(0, 1));
        if (fin[k]) begin
          if (hc[k] >= shold[k]) begin
            fin[k] = 1'b0;
            idx[k] = 0;
            hc[k] = 0;
          end else hc[k]++;
        end
      end
    end
    arc_finished = fin;
  end

  always @(negedge clk) begin
    if (rst) begin
      p_start = '0;
      p_fin = '0;
      p_more = 0;
      p_last = 0;
    end else begin
      chk("onehot", 32'($countones(arc_start) > 1), 0);
      for (int k = 0; k < 3; k++)
        if (p_start[k] && p_fin[k]) chk("leave_arc", 32'(arc_start[k]), 0);
      for (int k = 1; k < 3; k++)
        if (arc_start[k]) chk("overlap", 32'(arc_finished[k-1]), 0);
      if (p_more) chk("clear_gap", 32'(vga_plot), 1);
      if (p_last) chk("arc0_after_clear", 32'(arc_start), 1);
      if (arc_start != 0 && arc_start != p_start) seq.push_back(arc_start);
      c_more = 0;
      c_last = 0;
      if (vga_plot) begin
        plots++;
        if (q.size() == 0) chk("unexpected_plot", 32'(vga_plot), 0);
        else begin
          ce = q.pop_front();
          chk("pix_x", 32'(vga_x), ce.x);
          chk("pix_y", 32'(vga_y), ce.y);
          chk("pix_colour", 32'(vga_colour), ce.c);
          c_more = ce.kind == 1;
          c_last = ce.kind == 2;
        end
      end
      p_start = arc_start;
      p_fin = arc_finished;
      p_more = c_more;
      p_last = c_last;
    end
  end

  task automatic setup(input int cx, cy, d, col, cen, n0, n1, n2, h0, h1, h2);
    int h, k1, k2;
    sn[0] = n0; sn[1] = n1; sn[2] = n2;
    shold[0] = h0; shold[1] = h1; shold[2] = h2;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) begin
        sx[k][i] = $urandom_range(0, 255);
        sy[k][i] = $urandom_range(0, 127);
      end
    h = d / 2;
    k1 = d * 74 / 256;
    k2 = d * 148 / 256;
    ex[0] = cx - h; ey[0] = cy + k1;
    ex[1] = cx + h; ey[1] = cy + k1;
    ex[2] = cx;     ey[2] = cy - k2;
    exp_bad = 0;
    for (int k = 0; k < 3; k++)
      if (ex[k] < 0 || ex[k] >= 160 || ey[k] < 0 || ey[k] >= 120) exp_bad = 1;
    q.delete();
    seq.delete();
    plots = 0;
    if (!exp_bad) begin
      if (cen != 0)
        for (int y = 0; y < 120; y++)
          for (int x = 0; x < 160; x++)
            q.push_back(pix_t'{x, y, 0, (x == 159 && y == 119) ? 2 : 1});
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < sn[k]; i++) q.push_back(pix_t'{sx[k][i], sy[k][i], col, 0});
    end
    centre_x = 8'(cx);
    centre_y = 8'(cy);
    diameter = 8'(d);
    colour = 3'(col);
    clear_en = 1'(cen);
  endtask

  task automatic run(input int cx, cy, d, col, cen, n0, n1, n2, h0, h1, h2, hold, input bit early);
    int i;
    setup(cx, cy, d, col, cen, n0, n1, n2, h0, h1, h2);
    @(negedge clk);
    start = 1'b1;
    for (i = 0; i < 25000; i++) begin
      @(negedge clk);
      if (finished) break;
      if (early && i == 2) start = 1'b0;
    end
    if (i == 25000) begin
      chk("finish_timeout", 32'(finished), 1);
      start = 1'b0;
      return;
    end
    last_err = int'(err);
    chk("err", 32'(err), 32'(exp_bad));
    chk("queue_left", q.size(), 0);
    chk("arc_count", seq.size(), exp_bad ? 0 : 3);
    for (int k = 0; k < seq.size() && k < 3; k++) chk("arc_order", 32'(seq[k]), 1 << k);
    for (int k = 0; k < 3; k++) begin
      chk("arc_cx", 32'(arc_cx[k]), ex[k] & 255);
      chk("arc_cy", 32'(arc_cy[k]), ey[k] & 255);
    end
    chk("arc_radius", 32'(arc_radius), d);
    chk("arc_colour", 32'(arc_colour), col);
    for (int j = 0; j < hold && start; j++) begin
      @(negedge clk);
      chk("finished_hold", 32'(finished), 1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("finished_drop", 32'(finished), 0);
    chk("err_drop", 32'(err), 0);
  endtask

  initial begin
    int i;
    repeat (2) @(negedge clk);
    chk("rst_finished", 32'(finished), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_arc_start", 32'(arc_start), 0);
    chk("rst_vga_plot", 32'(vga_plot), 0);
    chk("rst_radius", 32'(arc_radius), 0);
    chk("rst_cx", 32'(arc_cx), 0);
    rst = 1'b0;
    run(80, 60, 80, 5, 0, 3, 2, 4, 1, 0, 2, 5, 0);
    chk("lit_cx0", 32'(arc_cx[0]), 40);
    chk("lit_cx1", 32'(arc_cx[1]), 120);
    chk("lit_cx2", 32'(arc_cx[2]), 80);
    chk("lit_cy0", 32'(arc_cy[0]), 83);
    chk("lit_cy2", 32'(arc_cy[2]), 14);
    chk("lit_radius", 32'(arc_radius), 80);
    run(10, 60, 40, 2, 0, 2, 2, 2, 0, 0, 0, 1, 0);
    chk("lit_err", last_err, 1);
    chk("lit_cx0_neg", 32'(arc_cx[0]), 246);
    chk("lit_err_plots", plots, 0);
    run(80, 60, 20, 6, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("lit_clear_plots", plots, 19203);
    run(80, 60, 80, 1, 0, 2, 0, 2, 0, 3, 0, 0, 0);
    run(200, 60, 20, 3, 1, 1, 1, 1, 0, 0, 0, 2, 0);
    setup(80, 60, 80, 2, 0, 2, 3, 2, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (arc_start == 3'b010) break;
    end
    chk("reach_arc1", 32'(arc_start), 3'b010);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_arc_start", 32'(arc_start), 0);
    chk("mid_rst_vga_plot", 32'(vga_plot), 0);
    chk("mid_rst_finished", 32'(finished), 0);
    q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(arc_start), 0);
    run(70, 50, 60, 7, 0, 2, 2, 2, 1, 1, 1, 2, 0);
    for (int r = 0; r < 12; r++)
      run(r % 2 ? $urandom_range(0, 255) : $urandom_range(50, 110),
          r % 3 ? $urandom_range(40, 90) : $urandom_range(0, 255),
          $urandom_range(0, 100), $urandom_range(0, 7), 0,
          $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
